// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared ALU opcodes, flag indices and mod_mult_seq states
package rsa_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_MOV = 3'b100
    } alu_op_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [2:0] {
        IDLE,
        DBL,
        RED1,
        ADDA,
        RED2,
        DONE
    } mms_state_e;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational shared ALU; after SUB, C=1 means no borrow
module alu
    import rsa_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [2:0]   i_op,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic [N-1:0] o_result,
    output logic [3:0]   o_flags
);

    logic [N:0]   w_sum;
    logic [N-1:0] w_res;
    logic         w_c;
    logic         w_v;

    always_comb begin
        w_sum = '0;
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (i_op)
            ALU_ADD: begin
                w_sum = {1'b0, i_a} + {1'b0, i_b};
                w_res = w_sum[N-1:0];
                w_c   = w_sum[N];
                w_v   = (i_a[N-1] == i_b[N-1]) && (w_res[N-1] != i_a[N-1]);
            end
            ALU_SUB: begin
                // Two's-complement subtract: the carry out is the inverted borrow.
                w_sum = {1'b0, i_a} + {1'b0, ~i_b} + (N+1)'(1);
                w_res = w_sum[N-1:0];
                w_c   = w_sum[N];
                w_v   = (i_a[N-1] != i_b[N-1]) && (w_res[N-1] != i_a[N-1]);
            end
            ALU_AND: w_res = i_a & i_b;
            ALU_OR:  w_res = i_a | i_b;
            ALU_MOV: w_res = i_b;
            default: w_res = '0;
        endcase
    end

    assign o_result        = w_res;
    assign o_flags[FLAG_N] = w_res[N-1];
    assign o_flags[FLAG_Z] = (w_res == '0);
    assign o_flags[FLAG_C] = w_c;
    assign o_flags[FLAG_V] = w_v;

endmodule

// File: rtl/mod_mult_seq.sv
// rtl/mod_mult_seq.sv - MSB-first double-and-add modular multiplier driving an external ALU
module mod_mult_seq
    import rsa_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic [N-1:0] n_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [N-1:0] result_o,
    output logic         err_o,
    output logic [2:0]   alu_opcode_o,
    output logic [N-1:0] alu_a_o,
    output logic [N-1:0] alu_b_o,
    input  logic [N-1:0] alu_result_i,
    input  logic [3:0]   alu_flags_i
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    mms_state_e   r_state;
    logic [N-1:0] r_a;
    logic [N-1:0] r_b;
    logic [N-1:0] r_n;
    logic [N-1:0] r_acc;
    logic [IW-1:0] r_idx;
    logic [N-1:0] r_result;
    logic         r_err;

    mms_state_e   w_next_state;
    logic [N-1:0] w_acc_next;
    alu_op_e      w_op;
    logic [N-1:0] w_alu_a;
    logic [N-1:0] w_alu_b;
    logic         w_accept;
    logic         w_bad_mod;
    logic         w_last_bit;
    logic         w_unused_flags;

    assign w_accept   = (r_state == IDLE) && start_i;
    // The modulus must be nonzero and below 2^(N-1) so 2R never overflows N bits.
    assign w_bad_mod  = (n_i == '0) || n_i[N-1];
    assign w_last_bit = (r_idx == '0);
    assign w_unused_flags = ^{alu_flags_i[FLAG_N], alu_flags_i[FLAG_Z], alu_flags_i[FLAG_V]};

    always_comb begin
        w_next_state = r_state;
        w_acc_next   = r_acc;
        w_op         = ALU_MOV;
        w_alu_a      = '0;
        w_alu_b      = '0;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_next_state = w_bad_mod ? DONE : DBL;
                end
            end
            DBL: begin
                w_op         = ALU_ADD;
                w_alu_a      = r_acc;
                w_alu_b      = r_acc;
                w_acc_next   = alu_result_i;
                w_next_state = RED1;
            end
            RED1: begin
                w_op       = ALU_SUB;
                w_alu_a    = r_acc;
                w_alu_b    = r_n;
                w_acc_next = alu_result_i[N-1:0];
                if (!alu_flags_i[FLAG_C]) begin
                    w_acc_next = r_acc;
                end
                w_next_state = ADDA;
            end
            ADDA: begin
                // Always issue the add, with 0 for a clear bit, so every bit costs four cycles.
                w_op         = ALU_ADD;
                w_alu_a      = r_acc;
                w_alu_b      = r_b[r_idx] ? r_a : '0;
                w_acc_next   = alu_result_i;
                w_next_state = RED2;
            end
            RED2: begin
                w_op       = ALU_SUB;
                w_alu_a    = r_acc;
                w_alu_b    = r_n;
                w_acc_next = alu_flags_i[FLAG_C] ? alu_result_i : r_acc;
                w_next_state = w_last_bit ? DONE : DBL;
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_n      <= '0;
            r_acc    <= '0;
            r_idx    <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_a      <= a_i;
                r_b      <= b_i;
                r_n      <= n_i;
                r_acc    <= '0;
                r_idx    <= IW'(N - 1);
                r_result <= '0;
                r_err    <= w_bad_mod;
            end else if (r_state == DBL || r_state == RED1 || r_state == ADDA) begin
                r_acc <= w_acc_next;
            end else if (r_state == RED2) begin
                r_acc <= w_acc_next;
                if (w_last_bit) begin
                    // Publish the final reduced value as DONE is entered so it is valid with done_o.
                    r_result <= w_acc_next;
                end else begin
                    r_idx <= r_idx - IW'(1);
                end
            end
        end
    end

    assign busy_o       = (r_state != IDLE);
    assign done_o       = (r_state == DONE);
    assign result_o     = r_result;
    assign err_o        = r_err;
    assign alu_opcode_o = w_op;
    assign alu_a_o      = w_alu_a;
    assign alu_b_o      = w_alu_b;

endmodule

// File: doc/mod_mult_seq.md
MOD_MULT_SEQ -- requirements
Module: mod_mult_seq

Interface
REQ-001 SHALL have parameter N, default 32, giving the operand/ALU data width.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i, input, 1, with synchronous, active-high reset.
REQ-004 SHALL have port start_i, input, 1, to request a modular multiply; it is sampled only in IDLE.
REQ-005 SHALL have ports a_i, b_i, n_i, input, N each, carrying multiplicand, multiplier and modulus.
REQ-006 SHALL have port busy_o, output, 1, high while an operation is in progress.
REQ-007 SHALL have port done_o, output, 1, a one-cycle pulse marking result_o/err_o valid.
REQ-008 SHALL have port result_o, output, N, holding (a*b) mod n, held until the next accepted start.
REQ-009 SHALL have port err_o, output, 1, flagging an illegal modulus; it is held with result_o.
REQ-010 SHALL have port alu_opcode_o, output, 3, carrying the opcode to the shared alu.
REQ-011 SHALL have ports alu_a_o, alu_b_o, output, N each, carrying the ALU operands.
REQ-012 SHALL have port alu_result_i, input, N, the combinational ALU result in the same cycle.
REQ-013 SHALL have port alu_flags_i, input, 4, carrying ALU flags {N,Z,C,V} at bits 3..0; after SUB, C=1 means no borrow (a>=b).

Function
REQ-014 SHALL use only ALU opcodes ADD=000 and SUB=001; in IDLE/DONE it SHALL drive opcode MOV=100 with operands 0.
REQ-015 SHALL, on start_i in IDLE, latch a_i, b_i and n_i, clear accumulator R to 0, set bit index i=N-1, clear err_o, and go to DBL.
REQ-016 SHALL, on start_i in IDLE with n_i==0 or n_i[N-1]==1, skip DBL and go to DONE with err_o=1 and result_o=0.
REQ-017 SHALL, in DBL, issue ADD(R,R) and load R from alu_result_i, then go to RED1.
REQ-018 SHALL, in RED1, issue SUB(R,n) and load R from alu_result_i only if C=1, then go to ADDA.
REQ-019 SHALL, in ADDA, issue ADD(R, b[i] ? a : 0) and load R, then go to RED2; this keeps per-bit timing fixed.
REQ-020 SHALL, in RED2, issue SUB(R,n) and load R only if C=1; at i==0 it SHALL go to DONE, otherwise decrement i and return to DBL.
REQ-021 SHALL, in DONE, copy R to result_o, assert done_o for exactly one cycle, and return to IDLE.
REQ-022 SHALL have a legal-operand latency of exactly 4N+1 rising edges from the start-sampling edge to the edge after which done_o is high (129 for N=32); the error latency SHALL be 1 edge.
REQ-023 SHALL hold busy_o high from the cycle after acceptance through DONE, inclusive.
REQ-024 SHALL ignore start_i in all states other than IDLE, including the DONE cycle.
REQ-025 SHALL produce a correct result only under the precondition a<n, with b unrestricted; with a>=n the result is unspecified but done_o timing is unchanged.
REQ-026 SHALL NOT let R overflow N bits, since n<2^(N-1) keeps R<2n before each reduction.

Reset
REQ-027 SHALL, with rst_i high at a rising edge, set state IDLE, busy_o=0, done_o=0, err_o=0, result_o=0, R=0, i=0 and latched operands to 0.
REQ-028 SHALL, on reset mid-operation, abandon the operation without a done_o pulse; a start in the first cycle after reset deasserts SHALL be accepted.
REQ-029 SHALL give rst_i priority over start_i in the same cycle.

Structure
REQ-030 SHALL place in the shared package rsa_pkg: the ALU opcode enum (ADD, SUB, AND, OR, MOV), the flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0, and the mod_mult_seq state enum {IDLE, DBL, RED1, ADDA, RED2, DONE}.
REQ-031 SHALL contain no sub-module; the ALU stays external so a CPU-level mux can share it, and both bench and integration SHALL pair the block with one alu instance of width N.

Verification
REQ-032 SHALL cover: a=7, b=5, n=11 -> result_o=2, err_o=0, done_o exactly 129 edges after start.
REQ-033 SHALL cover: a=9, b=0, n=13 -> result_o=0; and a=0x7FFFFFFE, b=0x7FFFFFFE, n=0x7FFFFFFF -> result_o=1.
REQ-034 SHALL cover: n=0x80000001 and, separately, n=0 -> done_o one edge after start, err_o=1, result_o=0.
REQ-035 SHALL cover: the ALU trace for the first 8 cycles after start with a=3, b=0x80000000, n=5, checking opcodes 000,001,000,001 repeating, and alu_b_o=3 in the first ADDA and 0 in the second.
REQ-036 SHALL cover: start re-pulsed at cycles 10 and 128 -> ignored; the single done_o pulse and result are unchanged.
REQ-037 SHALL cover: rst_i high at cycle 50 -> busy_o=0 and done_o never pulses; a restart with a=7, b=5, n=11 -> result_o=2.
